// File: rtl/aes128_cipher_iter.sv
// Iterative AES-128 encryption core: one FIPS-197 round per clock.
// Round keys are taken live from the externally expanded 44-word schedule.
// A block is accepted in IDLE, runs ten rounds in RUN, and the result is
// presented in DONE until the consumer takes it.
module aes128_cipher_iter (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  plaintext,
    input  logic [1407:0] w,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  ciphertext,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    fsm_t         fsm_r;
    logic [3:0]   round_r;
    logic [127:0] state_r;
    logic [127:0] ciphertext_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         busy_r;

    logic [127:0] sr_s;
    logic [127:0] mc_s;
    logic [127:0] rk_s;
    logic [127:0] rk0_s;
    logic [127:0] init_s;
    logic [127:0] mid_s;
    logic [127:0] final_s;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? p : 8'h00);
            p   = xtime(p);
        end
        return acc;
    endfunction

    // S-box from its algebraic definition: inverse a^254 (0 maps to 0),
    // then the affine transform. Constant-input logic, flattened by synthesis.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // SubBytes then ShiftRows. Byte n sits at bits [127-8n -: 8], row n%4, column n/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    // MixColumns: each output byte is 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3].
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0;
            o[111-32*c -: 8] = xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1;
            o[103-32*c -: 8] = xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2;
        end
        return o;
    endfunction

    // Round key rnd: schedule words 4*rnd..4*rnd+3, first word in the top bits.
    function automatic logic [127:0] round_key(input logic [1407:0] sched, input logic [3:0] rnd);
        logic [127:0] rk;
        rk = 128'd0;
        for (int i = 0; i < 4; i++) begin
            rk[127-32*i -: 32] = sched[128*int'(rnd) + 32*i +: 32];
        end
        return rk;
    endfunction

    // Round datapath: initial whitening, full middle round and final round.
    always_comb begin
        sr_s    = sub_shift(state_r);
        mc_s    = mix_columns(sr_s);
        rk_s    = round_key(w, round_r);
        rk0_s   = round_key(w, 4'd0);
        init_s  = plaintext ^ rk0_s;
        mid_s   = mc_s ^ rk_s;
        final_s = sr_s ^ rk_s;
    end

    // Control FSM, round state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_r        <= ST_IDLE;
            round_r      <= 4'd0;
            state_r      <= 128'd0;
            ciphertext_r <= 128'd0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_r    <= init_s;
                        round_r    <= 4'd1;
                        fsm_r      <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // The >= guard keeps the counter bounded even if it is ever corrupted.
                    if (round_r >= 4'd10) begin
                        ciphertext_r <= final_s;
                        round_r      <= 4'd0;
                        fsm_r        <= ST_DONE;
                        out_valid_r  <= 1'b1;
                    end else begin
                        state_r <= mid_s;
                        round_r <= round_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_r       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    fsm_r       <= ST_IDLE;
                    round_r     <= 4'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign ciphertext = ciphertext_r;

endmodule

// File: tb/tb_aes128_cipher_iter.sv
// Self-checking bench for aes128_cipher_iter: byte-array AES model with
// table-built S-box, a transaction-level protocol model compared every cycle,
// directed FIPS-197 scenarios and a randomized phase.
module tb_aes128_cipher_iter;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  plaintext = 128'd0;
    logic [1407:0] w = 1408'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [127:0]  ciphertext;
    logic          busy;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sbox_t [256];

    // protocol model: m_age = -1 idle, else edges since acceptance
    int           m_age = -1;
    logic [127:0] m_ct = 128'd0;
    logic [127:0] m_pend = 128'd0;
    int           cyc = 0;
    int           acc_cycle = 0;
    int           acc_count = 0;
    int           ov_pulses = 0;
    logic         ov_prev = 1'b0;

    aes128_cipher_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .w          (w),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_vec(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box via exp/log tables of generator 3, then the affine map.
    task automatic build_sbox();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = x;
            lg[x] = i;
            x = x ^ xt(x);
        end
        for (int a = 0; a < 256; a++) begin
            b = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
            sbox_t[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                          ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   kw [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] wv;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) kw[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = kw[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end
            kw[i] = kw[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) wv[32*i +: 32] = kw[i];
        return wv;
    endfunction

    // Textbook AES on a 16-byte state array s[4*col+row].
    function automatic logic [127:0] aes_model(input logic [1407:0] wv, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int n = 0; n < 16; n++) t[n] = sbox_t[s[n]];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++)
                        s[4*c+row] = t[4*((c+row)%4)+row];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int row = 0; row < 4; row++) t[row] = s[4*c+row];
                        for (int row = 0; row < 4; row++)
                            s[4*c+row] = xt(t[row]) ^ xt(t[(row+1)%4]) ^ t[(row+1)%4]
                                       ^ t[(row+2)%4] ^ t[(row+3)%4];
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = s[4*c+row] ^ wv[32*(4*r+c)+31-8*row -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    // Protocol model updated on each rising edge, DUT compared on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_age = -1;
                m_ct  = 128'd0;
            end else if (m_age < 0) begin
                if (in_valid) begin
                    m_age     = 0;
                    m_pend    = aes_model(w, plaintext);
                    acc_cycle = cyc;
                    acc_count++;
                end
            end else if (m_age < 10) begin
                m_age++;
                if (m_age == 10) m_ct = m_pend;
            end else if (out_ready) begin
                m_age = -1;
            end
            @(negedge clk);
            check_bit("in_ready", in_ready, m_age < 0);
            check_bit("busy", busy, m_age >= 0);
            check_bit("out_valid", out_valid, m_age >= 10);
            check_vec("ciphertext", ciphertext, m_ct);
            if (out_valid === 1'b1 && ov_prev === 1'b0) ov_pulses++;
            ov_prev = out_valid;
        end
    end

    // Offer a block from a falling edge; returns just after the accepting edge.
    task automatic offer(input logic [127:0] key, input logic [127:0] pt);
        int c0;
        bit ok;
        c0 = acc_count;
        ok = 1'b0;
        w = expand_key(key);
        plaintext = pt;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (acc_count != c0);
        end
        in_valid = 1'b0;
        check_bit("accept_timeout", ok, 1'b1);
    endtask

    // Wait on falling edges for out_valid; lat counts edges past acceptance.
    task automatic wait_out(output int lat);
        bit ok;
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) ok = 1'b1;
            else lat++;
        end
        check_bit("out_valid_timeout", ok, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1407:0] wv;
        logic [127:0]  held;
        int            lat;
        int            prev_acc;
        build_sbox();

        // pin the model with hand-known values
        check_vec("sbox_00", {120'd0, sbox_t[0]}, {120'd0, 8'h63});
        check_vec("sbox_01", {120'd0, sbox_t[1]}, {120'd0, 8'h7c});
        check_vec("sbox_53", {120'd0, sbox_t[8'h53]}, {120'd0, 8'hed});
        wv = expand_key(KEY_B);
        check_vec("keyexp_w4", {96'd0, wv[159:128]}, {96'd0, 32'ha0fafe17});
        check_vec("keyexp_w40", {96'd0, wv[1311:1280]}, {96'd0, 32'hd014f9a8});
        check_vec("model_appB", aes_model(expand_key(KEY_B), PT_B), CT_B);
        check_vec("model_appC1", aes_model(expand_key(KEY_C), PT_C), CT_C);

        // reset
        repeat (3) @(negedge clk);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_vec("rst_ciphertext", ciphertext, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // App. B, out_ready high: 10-cycle latency, one-cycle out_valid
        out_ready = 1'b1;
        ov_pulses = 0;
        offer(KEY_B, PT_B);
        wait_out(lat);
        check_int("latency_B", lat, 10);
        check_vec("ct_appB", ciphertext, CT_B);
        @(negedge clk);
        check_bit("ov_one_cycle", out_valid, 1'b0);
        check_bit("ready_after_hs", in_ready, 1'b1);

        // App. C.1
        offer(KEY_C, PT_C);
        wait_out(lat);
        check_int("latency_C", lat, 10);
        check_vec("ct_appC1", ciphertext, CT_C);
        @(negedge clk);

        // backpressure: 7 stalled cycles, handshake on the 8th
        out_ready = 1'b0;
        offer(KEY_B, PT_B);
        wait_out(lat);
        held = ciphertext;
        check_vec("bp_ct", held, CT_B);
        for (int i = 0; i < 7; i++) begin
            check_bit("bp_valid", out_valid, 1'b1);
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_vec("bp_stable", ciphertext, held);
            @(negedge clk);
        end
        check_bit("bp_valid8", out_valid, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        check_bit("bp_release_ready", in_ready, 1'b1);
        check_bit("bp_release_valid", out_valid, 1'b0);

        // busy-input rejection
        ov_pulses = 0;
        offer(KEY_B, PT_B);
        @(negedge clk);
        in_valid = 1'b1;
        plaintext = 128'd0;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        check_vec("busy_reject_ct", ciphertext, CT_B);
        repeat (15) @(negedge clk);
        check_int("busy_reject_pulses", ov_pulses, 1);

        // reset mid-RUN, then App. C.1
        ov_pulses = 0;
        offer(KEY_B, PT_B);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_bit("midrst_in_ready", in_ready, 1'b1);
        check_vec("midrst_ct", ciphertext, 128'd0);
        offer(KEY_C, PT_C);
        wait_out(lat);
        check_vec("after_rst_ct", ciphertext, CT_C);
        @(negedge clk);
        check_int("midrst_pulses", ov_pulses, 1);

        // streaming: four alternating blocks, in_valid and out_ready high
        w = expand_key(KEY_B);
        plaintext = PT_B;
        in_valid = 1'b1;
        prev_acc = 0;
        for (int blk = 0; blk < 4; blk++) begin
            wait_out(lat);
            check_vec("stream_ct", ciphertext, (blk % 2 == 0) ? CT_B : CT_C);
            if (blk > 0) check_int("stream_period", acc_cycle - prev_acc, 12);
            prev_acc = acc_cycle;
            if (blk == 3) begin
                in_valid = 1'b0;
            end else begin
                w = expand_key((blk % 2 == 0) ? KEY_C : KEY_B);
                plaintext = (blk % 2 == 0) ? PT_C : PT_B;
            end
        end
        repeat (3) @(negedge clk);

        // randomized traffic; w only changes when no block is in flight
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (m_age < 0 || m_age >= 10)
                w = expand_key({$urandom, $urandom, $urandom, $urandom});
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            in_valid = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
